// File: rtl/pipeline_reg_elastic.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapse and
// an optional input skid buffer that makes in_ready a flop output.
module pipeline_reg_elastic #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2,
    parameter int REG_READY = 1,
    parameter int CNT_W     = $clog2(DEPTH + REG_READY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH-1:0] can_ld;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             in_xfer;
    logic             out_xfer;

    // Stage i may load when any stage from i to the end is empty or the tail drains;
    // written without a bit-to-bit chain to keep the vector free of self-dependence.
    always_comb begin
        can_ld = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            can_ld[i] = out_ready;
            for (int unsigned j = i; j < DEPTH; j++) begin
                if (!vld[j]) can_ld[i] = 1'b1;
            end
        end
    end

    assign out_valid = vld[DEPTH-1] & ~flush;
    assign out_data  = dat[DEPTH-1];
    assign out_xfer  = out_valid & out_ready;
    assign in_xfer   = in_valid & in_ready;

    if (REG_READY != 0) begin : g_skid
        logic             skid_valid;
        logic [WIDTH-1:0] skid_data;

        assign in_ready  = ~skid_valid & ~flush;
        assign src_valid = skid_valid | in_xfer;
        assign src_data  = skid_valid ? skid_data : in_data;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else if (flush) begin
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else if (skid_valid && can_ld[0]) begin
                skid_valid <= 1'b0;
            end else if (in_xfer && !can_ld[0]) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end else begin : g_noskid
        assign in_ready  = can_ld[0] & ~flush;
        assign src_valid = in_xfer;
        assign src_data  = in_data;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             v;
        logic [WIDTH-1:0] d;
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (g == 0) begin : g_head
            assign up_v = src_valid;
            assign up_d = src_data;
        end else begin : g_body
            assign up_v = vld[g-1];
            assign up_d = dat[g-1];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v <= 1'b0;
                d <= '0;
            end else if (flush) begin
                v <= 1'b0;
                d <= '0;
            end else if (can_ld[g]) begin
                v <= up_v;
                if (up_v) d <= up_d;
            end
        end

        assign vld[g] = v;
        assign dat[g] = d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule
